// File: rtl/traffic_conflict_monitor.sv
// Traffic conflict monitor: forwards legal controller light codes to the lamps
// with one cycle of latency. Invalid codes, crossing greens and short/skipped
// yellows are detected. Any of these latches a fault and the lamps flash red.
module traffic_conflict_monitor #(
    parameter int unsigned CONFLICT_CYCLES = 2,
    parameter int unsigned MIN_YELLOW      = 3,
    parameter int unsigned FLASH_HALF      = 25,
    parameter int unsigned INIT_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] east,
    input  logic [2:0] west,
    input  logic [2:0] north,
    input  logic [2:0] south,
    output logic [2:0] lamp_e,
    output logic [2:0] lamp_w,
    output logic [2:0] lamp_n,
    output logic [2:0] lamp_s,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       flash
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam int unsigned CW = $clog2(CONFLICT_CYCLES + 1);
    localparam int unsigned YW = $clog2(MIN_YELLOW + 1);
    localparam int unsigned FW = $clog2(FLASH_HALF + 1);
    localparam int unsigned IW = $clog2(INIT_CYCLES + 1);

    localparam logic [CW-1:0] CONF_MAX   = CW'(CONFLICT_CYCLES);
    localparam logic [YW-1:0] YEL_MAX    = YW'(MIN_YELLOW);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
    localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {StInit, StRun, StFlash} state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [IW-1:0]   r_init_cnt;
    logic [IW-1:0]   w_init_nxt;
    logic [CW-1:0]   r_inv_cnt;
    logic [CW-1:0]   w_inv_nxt;
    logic [CW-1:0]   r_conf_cnt;
    logic [CW-1:0]   w_conf_nxt;
    logic [YW-1:0]   r_ycnt [4];
    logic [YW-1:0]   w_ycnt_nxt [4];
    logic [2:0]      r_lamp [4];
    logic [2:0]      w_lamp_nxt [4];
    logic            r_fault;
    logic            w_fault_nxt;
    logic [1:0]      r_code;
    logic [1:0]      w_code_nxt;
    logic [FW-1:0]   r_flash_cnt;
    logic [FW-1:0]   w_fcnt_nxt;
    logic            r_flash_on;
    logic            w_fon_nxt;
    logic            w_trip;

    logic [2:0]      w_in [4];
    logic            w_valid;
    logic            w_ew_go;
    logic            w_ns_go;
    logic            w_conflict;
    logic            w_good;
    logic            w_short;

    // Approach order used throughout: 0=east, 1=west, 2=north, 3=south.
    assign w_in[0] = east;
    assign w_in[1] = west;
    assign w_in[2] = north;
    assign w_in[3] = south;

    // Classify the current sample: legality, crossing greens, short yellow.
    always_comb begin
        w_valid = 1'b1;
        w_short = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!(w_in[i] == RED || w_in[i] == YEL || w_in[i] == GRN)) begin
                w_valid = 1'b0;
            end
        end
        w_ew_go    = (w_in[0] != RED) || (w_in[1] != RED);
        w_ns_go    = (w_in[2] != RED) || (w_in[3] != RED);
        w_conflict = w_valid && w_ew_go && w_ns_go;
        w_good     = w_valid && !w_conflict;
        // Short yellow compares against the code last forwarded to the lamp.
        for (int i = 0; i < 4; i++) begin
            if (w_good && w_in[i] == RED &&
                (r_lamp[i] == GRN || (r_lamp[i] == YEL && r_ycnt[i] < YEL_MAX))) begin
                w_short = 1'b1;
            end
        end
    end

    // Next-state and datapath next values for every register.
    always_comb begin
        w_state_nxt = r_state;
        w_init_nxt  = r_init_cnt;
        w_inv_nxt   = r_inv_cnt;
        w_conf_nxt  = r_conf_cnt;
        w_fault_nxt = r_fault;
        w_code_nxt  = r_code;
        w_fcnt_nxt  = r_flash_cnt;
        w_fon_nxt   = r_flash_on;
        w_trip      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_ycnt_nxt[i] = r_ycnt[i];
            w_lamp_nxt[i] = r_lamp[i];
        end

        unique case (r_state)
            StInit: begin
                w_inv_nxt  = '0;
                w_conf_nxt = '0;
                w_fcnt_nxt = '0;
                w_fon_nxt  = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    w_ycnt_nxt[i] = '0;
                    w_lamp_nxt[i] = RED;
                end
                if (r_init_cnt == INIT_LAST) begin
                    w_init_nxt  = '0;
                    w_state_nxt = StRun;
                end else begin
                    w_init_nxt = r_init_cnt + 1'b1;
                end
            end

            StRun: begin
                if (w_valid) begin
                    w_inv_nxt = '0;
                end else if (r_inv_cnt != CONF_MAX) begin
                    w_inv_nxt = r_inv_cnt + 1'b1;
                end
                if (!w_conflict) begin
                    w_conf_nxt = '0;
                end else if (r_conf_cnt != CONF_MAX) begin
                    w_conf_nxt = r_conf_cnt + 1'b1;
                end
                for (int i = 0; i < 4; i++) begin
                    if (w_in[i] != YEL) begin
                        w_ycnt_nxt[i] = '0;
                    end else if (r_ycnt[i] != YEL_MAX) begin
                        w_ycnt_nxt[i] = r_ycnt[i] + 1'b1;
                    end
                    w_lamp_nxt[i] = w_good ? w_in[i] : RED;
                end
                // Priority: conflict, then invalid, then short yellow.
                if (w_conflict && w_conf_nxt == CONF_MAX) begin
                    w_trip     = 1'b1;
                    w_code_nxt = 2'b10;
                end else if (!w_valid && w_inv_nxt == CONF_MAX) begin
                    w_trip     = 1'b1;
                    w_code_nxt = 2'b01;
                end else if (w_short) begin
                    w_trip     = 1'b1;
                    w_code_nxt = 2'b11;
                end
                if (w_trip) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = StFlash;
                    w_fcnt_nxt  = '0;
                    w_fon_nxt   = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        w_lamp_nxt[i] = RED;
                    end
                end
            end

            StFlash: begin
                if (r_flash_cnt == FLASH_LAST) begin
                    w_fcnt_nxt = '0;
                    w_fon_nxt  = ~r_flash_on;
                end else begin
                    w_fcnt_nxt = r_flash_cnt + 1'b1;
                end
                for (int i = 0; i < 4; i++) begin
                    w_lamp_nxt[i] = w_fon_nxt ? RED : OFF;
                end
            end

            default: begin
                w_state_nxt = StInit;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StInit;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, latched fault and registered lamp drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_init_cnt  <= '0;
            r_inv_cnt   <= '0;
            r_conf_cnt  <= '0;
            r_fault     <= 1'b0;
            r_code      <= 2'b00;
            r_flash_cnt <= '0;
            r_flash_on  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_ycnt[i] <= '0;
                r_lamp[i] <= RED;
            end
        end else begin
            r_init_cnt  <= w_init_nxt;
            r_inv_cnt   <= w_inv_nxt;
            r_conf_cnt  <= w_conf_nxt;
            r_fault     <= w_fault_nxt;
            r_code      <= w_code_nxt;
            r_flash_cnt <= w_fcnt_nxt;
            r_flash_on  <= w_fon_nxt;
            for (int i = 0; i < 4; i++) begin
                r_ycnt[i] <= w_ycnt_nxt[i];
                r_lamp[i] <= w_lamp_nxt[i];
            end
        end
    end

    assign lamp_e     = r_lamp[0];
    assign lamp_w     = r_lamp[1];
    assign lamp_n     = r_lamp[2];
    assign lamp_s     = r_lamp[3];
    assign fault      = r_fault;
    assign fault_code = r_code;
    assign flash      = (r_state == StFlash);

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed scenarios plus randomized
// signal-phase sequences, checked against a run-length / elapsed-time model.
module tb_traffic_conflict_monitor;

    localparam int CC    = 2;
    localparam int MINY  = 3;
    localparam int HALF  = 25;
    localparam int INITC = 4;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk;
    logic       reset;
    logic [2:0] east, west, north, south;
    logic [2:0] lamp_e, lamp_w, lamp_n, lamp_s;
    logic       fault;
    logic [1:0] fault_code;
    logic       flash;

    int total = 0;
    int bad   = 0;

    // Model state: 0 = init hold, 1 = running, 2 = flashing.
    int         m_mode;
    int         m_init_edges;
    int         m_inv_run;
    int         m_conf_run;
    int         m_yrun [4];
    logic [2:0] m_lamp [4];
    logic       m_fault;
    logic [1:0] m_code;
    int         m_age;

    traffic_conflict_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .east       (east),
        .west       (west),
        .north      (north),
        .south      (south),
        .lamp_e     (lamp_e),
        .lamp_w     (lamp_w),
        .lamp_n     (lamp_n),
        .lamp_s     (lamp_s),
        .fault      (fault),
        .fault_code (fault_code),
        .flash      (flash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("lamps", {lamp_e, lamp_w, lamp_n, lamp_s},
            {m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3]});
        chk("fault", {9'd0, fault, fault_code}, {9'd0, m_fault, m_code});
        chk("flash", {11'd0, flash}, {11'd0, (m_mode == 2)});
    endtask

    task automatic model_reset();
        m_mode       = 0;
        m_init_edges = 0;
        m_inv_run    = 0;
        m_conf_run   = 0;
        m_fault      = 1'b0;
        m_code       = 2'b00;
        m_age        = 0;
        for (int i = 0; i < 4; i++) begin
            m_yrun[i] = 0;
            m_lamp[i] = R;
        end
    endtask

    task automatic model_edge(input logic [2:0] a0, input logic [2:0] a1,
                              input logic [2:0] a2, input logic [2:0] a3);
        logic [2:0] in [4];
        bit valid, confl, good, short_y;
        logic [1:0] code;
        in[0] = a0; in[1] = a1; in[2] = a2; in[3] = a3;
        if (m_mode == 0) begin
            m_init_edges++;
            if (m_init_edges == INITC) m_mode = 1;
        end else if (m_mode == 1) begin
            valid = 1;
            for (int i = 0; i < 4; i++)
                if (in[i] != R && in[i] != Y && in[i] != G) valid = 0;
            confl = valid && (a0 != R || a1 != R) && (a2 != R || a3 != R);
            good  = valid && !confl;
            short_y = 0;
            for (int i = 0; i < 4; i++)
                if (good && in[i] == R &&
                    (m_lamp[i] == G || (m_lamp[i] == Y && m_yrun[i] < MINY)))
                    short_y = 1;
            m_inv_run  = valid ? 0 : m_inv_run + 1;
            m_conf_run = confl ? m_conf_run + 1 : 0;
            for (int i = 0; i < 4; i++)
                m_yrun[i] = (in[i] == Y) ? m_yrun[i] + 1 : 0;
            if (m_conf_run >= CC)     code = 2'b10;
            else if (m_inv_run >= CC) code = 2'b01;
            else if (short_y)         code = 2'b11;
            else                      code = 2'b00;
            if (code != 2'b00) begin
                m_fault = 1'b1;
                m_code  = code;
                m_mode  = 2;
                m_age   = 0;
                for (int i = 0; i < 4; i++) m_lamp[i] = R;
            end else begin
                for (int i = 0; i < 4; i++) m_lamp[i] = good ? in[i] : R;
            end
        end else begin
            m_age++;
            for (int i = 0; i < 4; i++)
                m_lamp[i] = (((m_age / HALF) % 2) == 0) ? R : 3'b000;
        end
    endtask

    // Called at a falling edge: drive, clock once, check at the next falling edge.
    task automatic step(input logic [2:0] a0, input logic [2:0] a1,
                        input logic [2:0] a2, input logic [2:0] a3);
        east = a0; west = a1; north = a2; south = a3;
        @(posedge clk);
        model_edge(a0, a1, a2, a3);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset: outputs are checked 1 time unit after assertion,
    // well before any clock edge.
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        check_all();
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] cc [4];
        int ph;
        int left;

        reset = 1'b1;
        east = G; west = G; north = R; south = R;
        @(negedge clk);

        // Power-up hold then mirroring.
        do_reset();
        repeat (8) step(G, G, R, R);

        // Normal full cycle.
        repeat (5) step(G, G, R, R);
        repeat (3) step(Y, Y, R, R);
        step(R, R, R, R);
        repeat (5) step(R, R, G, G);
        repeat (3) step(R, R, Y, Y);
        step(R, R, R, R);
        repeat (2) step(G, G, R, R);

        // Single-cycle conflict is masked, two cycles latch code 10.
        step(G, R, G, R);
        repeat (2) step(G, R, R, R);
        repeat (2) step(G, R, G, R);
        repeat (3) step(G, R, R, R);

        // Short yellow, then green straight to red.
        do_reset();
        repeat (7) step(G, G, R, R);
        repeat (2) step(Y, Y, R, R);
        repeat (3) step(R, R, R, R);
        do_reset();
        repeat (6) step(G, G, R, R);
        repeat (3) step(R, R, R, R);

        // Invalid code latches 01; flash pattern with ignored inputs.
        do_reset();
        repeat (6) step(G, G, R, R);
        repeat (2) step(G, 3'b011, R, R);
        for (int k = 0; k < 60; k++)
            step(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));

        // Reset mid-flash, then fresh init hold.
        do_reset();
        repeat (6) step(R, R, G, G);

        // Randomized phase sequences with occasional glitches.
        for (int ep = 0; ep < 12; ep++) begin
            do_reset();
            repeat (INITC + 1) step(G, G, R, R);
            ph   = 0;
            left = $urandom_range(1, 5);
            for (int c = 0; c < 60; c++) begin
                case (ph)
                    0:       begin cc[0] = G; cc[1] = G; cc[2] = R; cc[3] = R; end
                    1:       begin cc[0] = Y; cc[1] = Y; cc[2] = R; cc[3] = R; end
                    3:       begin cc[0] = R; cc[1] = R; cc[2] = G; cc[3] = G; end
                    4:       begin cc[0] = R; cc[1] = R; cc[2] = Y; cc[3] = Y; end
                    default: begin cc[0] = R; cc[1] = R; cc[2] = R; cc[3] = R; end
                endcase
                if ($urandom_range(0, 29) == 0)
                    cc[$urandom_range(0, 3)] = 3'($urandom);
                step(cc[0], cc[1], cc[2], cc[3]);
                left--;
                if (left == 0) begin
                    ph   = (ph + 1) % 6;
                    left = (ph == 1 || ph == 4) ? $urandom_range(2, 4) : $urandom_range(1, 5);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001: The parameter CONFLICT_CYCLES SHALL default to 2; it is the number of consecutive bad samples needed to latch a fault.
REQ-002: The parameter MIN_YELLOW SHALL default to 3; it is the minimum number of consecutive yellow cycles allowed before red.
REQ-003: The parameter FLASH_HALF SHALL default to 25; it is the number of cycles in each half-period of the fault flash.
REQ-004: The parameter INIT_CYCLES SHALL default to 4; it is the forced all-red hold after reset.
REQ-005: clk  input  1  system clock; all state updates on its rising edge.
REQ-006: reset  input  1  asynchronous, active-low reset.
REQ-007: east, west, north, south  input  3 each  light codes from the controller: bit2=red, bit1=yellow, bit0=green.
REQ-008: lamp_e, lamp_w, lamp_n, lamp_s  output  3 each  registered lamp drive, same encoding as the inputs.
REQ-009: fault  output  1  latched fault indicator.
REQ-010: fault_code  output  2  cause of the latched fault: 01 invalid code, 10 conflict, 11 short yellow or skipped yellow.
REQ-011: flash  output  1  high while in the FLASH state.

Function
REQ-012: The FSM SHALL have exactly three states, INIT, RUN and FLASH, with these transitions:
- reset -> INIT
- INIT -> RUN after INIT_CYCLES clock edges
- RUN -> FLASH on a latched fault
- FLASH is exited only by reset.
REQ-013: In INIT, all lamps SHALL be 3'b100 and all checkers SHALL be disabled, with their counters held at zero.
REQ-014: A sample SHALL be invalid if any approach code is not one of 3'b100, 3'b010 or 3'b001.
REQ-015: A sample SHALL be conflicting if it is valid and (east or west is non-red) and (north or south is non-red).
REQ-016: In RUN, a valid, non-conflicting sample SHALL be registered to the lamp outputs with 1-cycle latency, so lamp_x equals the input from the previous edge.
REQ-017: In RUN, an invalid or conflicting sample SHALL drive all four lamps to 3'b100 for that cycle instead of being forwarded.
REQ-018: The monitor SHALL keep a saturating counter of consecutive invalid samples and a separate one of consecutive conflicting samples; any sample not in a counter's class SHALL clear that counter.
REQ-019: Each approach SHALL have a yellow counter that counts consecutive yellow samples and saturates at MIN_YELLOW; it SHALL clear on any non-yellow sample.
REQ-020: A short-yellow event SHALL occur on a valid, non-conflicting sample where an approach becomes red and its previous forwarded code was green, or was yellow with a counter below MIN_YELLOW.
REQ-021: A fault SHALL latch on the edge at which any of the following occurs:
- the invalid counter reaches CONFLICT_CYCLES;
- the conflict counter reaches CONFLICT_CYCLES;
- a short-yellow event occurs.
REQ-022: On the latching edge, fault SHALL go to 1, flash SHALL go to 1, and the state SHALL become FLASH.
REQ-023: When several fault causes coincide on one edge, fault_code priority SHALL be conflict (10), then invalid (01), then short yellow (11).
REQ-024: fault and fault_code SHALL hold their values until reset; no later cause SHALL overwrite them.
REQ-025: In FLASH, all four lamps SHALL toggle between 3'b100 (on phase) and 3'b000 (off phase).
REQ-026: The flash SHALL start with the on phase on the latching edge, and each phase SHALL last FLASH_HALF cycles using a counter that wraps from FLASH_HALF-1 to 0.
REQ-027: In FLASH, the inputs SHALL be ignored.
REQ-028: All counters SHALL be sized to hold their parameter value without overflow.

Reset
REQ-029: While reset is low, all lamps SHALL be 3'b100, fault and flash SHALL be 0, fault_code SHALL be 00, all counters SHALL be 0, and the state SHALL be INIT; the outputs SHALL take these values immediately, independent of clk.
REQ-030: Reset asserted in any state, including FLASH, SHALL abort that state immediately and clear the latched fault.

Verification
REQ-031: Reset low, then released with inputs at east=west=3'b001 and north=south=3'b100 -> lamps stay all 3'b100 for 4 edges, then mirror the inputs 1 cycle later with fault=0.
REQ-032: A normal sequence (E/W green 5 cycles, yellow 3 cycles, red; then N/S green) -> lamps mirror the inputs with 1-cycle latency and fault stays 0.
REQ-033: east=3'b001 and north=3'b001 for 1 cycle -> lamps all 3'b100 for that cycle and no fault; the same for 2 cycles -> fault=1, fault_code=10, flash=1 on the 2nd edge.
REQ-034: East yellow for 2 cycles then red -> fault_code=11 on the red edge; east green directly to red -> fault_code=11.
REQ-035: west=3'b011 for 2 cycles -> fault_code=01; lamps then show 3'b100 for 25 cycles, 3'b000 for 25 cycles, repeating, while the inputs are ignored.
REQ-036: Reset pulsed low mid-FLASH -> lamps immediately 3'b100 and fault=0, followed by a fresh INIT hold of 4 edges.
